// File: rtl/scoot_world.sv
// scoot_world: grid-world environment for a scoot-bot agent.
// Holds a WIDTH x HEIGHT food map, tracks the bot position on a torus, presents the
// four neighbour light sensors and scores the food collected over a fixed-length run.
module scoot_world #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned HEIGHT  = 10,
  parameter int unsigned STEPS   = 64,
  parameter int unsigned SCORE_W = 8,
  localparam int unsigned XW     = $clog2(WIDTH),
  localparam int unsigned YW     = $clog2(HEIGHT)
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               load,
  input  logic [XW-1:0]      loadCol,
  input  logic [HEIGHT-1:0]  loadData,
  input  logic               start,
  input  logic               mUp,
  input  logic               mRight,
  input  logic               mDown,
  input  logic               mLeft,
  output logic               lUp,
  output logic               lRight,
  output logic               lDown,
  output logic               lLeft,
  output logic [XW-1:0]      posX,
  output logic [YW-1:0]      posY,
  output logic               pickup,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               done
);

  // Step counter must be at least one bit wide even for single-step runs.
  localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [XW-1:0] XMax     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMax     = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] XMid     = XW'(WIDTH / 2);
  localparam logic [YW-1:0] YMid     = YW'(HEIGHT / 2);
  localparam logic [CW-1:0] StepLast = CW'(STEPS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

  stateT              stateQ, stateD;
  logic [HEIGHT-1:0]  gridQ [WIDTH];
  logic [XW-1:0]      posXQ, posXD;
  logic [YW-1:0]      posYQ, posYD;
  logic [SCORE_W-1:0] scoreQ, scoreD;
  logic [CW-1:0]      stepQ, stepD;
  logic               pickupQ, pickupD;
  logic               loadEn;
  logic               clearEn;
  logic [XW-1:0]      xInc, xDec;
  logic [YW-1:0]      yInc, yDec;
  logic               foodHere;

  // Toroidal neighbour coordinates of the current position.
  always_comb begin
    xInc = (posXQ == XMax) ? '0 : posXQ + 1'b1;
    xDec = (posXQ == '0) ? XMax : posXQ - 1'b1;
    yInc = (posYQ == YMax) ? '0 : posYQ + 1'b1;
    yDec = (posYQ == '0) ? YMax : posYQ - 1'b1;
  end

  assign foodHere = gridQ[posXQ][posYQ];

  // Sensors depend only on registered state, never on the motion inputs.
  assign lUp    = gridQ[posXQ][yInc];
  assign lRight = gridQ[xInc][posYQ];
  assign lDown  = gridQ[posXQ][yDec];
  assign lLeft  = gridQ[xDec][posYQ];

  // Next-state logic: load/start handling when idle or done, one step per cycle in run.
  always_comb begin
    stateD  = stateQ;
    posXD   = posXQ;
    posYD   = posYQ;
    scoreD  = scoreQ;
    stepD   = stepQ;
    pickupD = 1'b0;
    loadEn  = 1'b0;
    clearEn = 1'b0;
    unique case (stateQ)
      StIdle, StDone: begin
        loadEn = load && (32'(loadCol) < WIDTH);
        if (start) begin
          stateD = StRun;
          posXD  = XMid;
          posYD  = YMid;
          scoreD = '0;
          stepD  = '0;
        end
      end
      StRun: begin
        if (foodHere) begin
          clearEn = 1'b1;
          pickupD = 1'b1;
          if (scoreQ != '1) scoreD = scoreQ + 1'b1;
        end
        // Opposing commands cancel; x and y move independently so diagonals work.
        if (mRight && !mLeft) posXD = xInc;
        else if (mLeft && !mRight) posXD = xDec;
        if (mUp && !mDown) posYD = yInc;
        else if (mDown && !mUp) posYD = yDec;
        stepD = stepQ + 1'b1;
        if (stepQ == StepLast) stateD = StDone;
      end
      default: stateD = StIdle;
    endcase
  end

  // Control and position registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stateQ  <= StIdle;
      posXQ   <= XMid;
      posYQ   <= YMid;
      scoreQ  <= '0;
      stepQ   <= '0;
      pickupQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      posXQ   <= posXD;
      posYQ   <= posYD;
      scoreQ  <= scoreD;
      stepQ   <= stepD;
      pickupQ <= pickupD;
    end
  end

  // Food map: column writes from load, single-cell clear on pickup.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int c = 0; c < WIDTH; c++) gridQ[c] <= '0;
    end else begin
      for (int c = 0; c < WIDTH; c++) begin
        if (loadEn && (loadCol == XW'(c))) gridQ[c] <= loadData;
        else if (clearEn && (posXQ == XW'(c))) gridQ[c][posYQ] <= 1'b0;
      end
    end
  end

  assign posX   = posXQ;
  assign posY   = posYQ;
  assign pickup = pickupQ;
  assign score  = scoreQ;
  assign busy   = (stateQ == StRun);
  assign done   = (stateQ == StDone);

endmodule

// File: doc/scoot_world.md
# scoot_world

Hardware grid world that drives a scoot-bot agent: holds a WIDTH×HEIGHT food map, tracks the bot's position, and presents the four neighbour-cell light sensors. Each step it consumes the bot's four motion commands, collects food at the current cell, and moves the bot with toroidal wrap-around. It is the environment end of the bot interface: its sensor outputs feed the bot's light inputs, and the bot's motion outputs feed back into this block. It replaces the behavioural simulator loop with synthesizable RTL so agent fitness can be scored in hardware.

## Interface
- WIDTH, 10, grid columns (x); must be ≥3
- HEIGHT, 10, grid rows (y); must be ≥3
- STEPS, 64, steps per run; must be ≥1
- SCORE_W, 8, score counter width
- XW / YW, derived: clog2(WIDTH) / clog2(HEIGHT)

- clock  in  1  single clock; all state updates on posedge
- resetN  in  1  asynchronous, active-low reset
- load  in  1  write loadData into grid column loadCol
- loadCol  in  XW  column index; writes with loadCol ≥ WIDTH are ignored
- loadData  in  HEIGHT  column contents; bit y = cell (loadCol, y)
- start  in  1  begin a run
- mUp, mRight, mDown, mLeft  in  1 each  bot motion commands
- lUp, lRight, lDown, lLeft  out  1 each  food at (x, y+1), (x+1, y), (x, y−1), (x−1, y), all indices mod grid size
- posX  out  XW  current bot x
- posY  out  YW  current bot y
- pickup  out  1  one-cycle pulse: food collected this step
- score  out  SCORE_W  food collected this run
- busy  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- Grid: WIDTH registers of HEIGHT bits, cell(x,y) = grid[x][y].
- States IDLE, RUN, DONE.
- IDLE: load accepted. start → RUN; same edge sets posX=WIDTH/2, posY=HEIGHT/2, score=0, step counter=0.
- RUN, each cycle is one step:
  - If cell(posX,posY)=1: clear it, pulse pickup, score+1 (saturates at 2^SCORE_W−1).
  - Move: x += mRight−mLeft, y += mUp−mDown, each mod its dimension (0−1 wraps to max, max+1 wraps to 0). Opposing commands cancel; diagonal moves allowed.
  - Step counter +1; after step STEPS−1 → DONE. Cell at final position is not collected.
  - load and start ignored.
- DONE: score, posX, posY held. load accepted. start → RUN with same re-centre/clear as from IDLE; grid not reloaded.
- load and start in the same cycle (IDLE/DONE): write applied; run starts; first step sees written data.
- Sensor outputs are combinational from grid, posX and posY registers. They carry no combinational path from m* inputs.

## Timing
- Reset (async assert, any state): state=IDLE, grid all 0, posX=WIDTH/2, posY=HEIGHT/2, score=0, counter=0, pickup=0, busy=0, done=0. Sensors therefore read 0.
- Start latency: start sampled at edge N; busy high from N; first step evaluated in the cycle after N and committed at edge N+1.
- Run length: busy high exactly STEPS cycles; done rises at the edge ending the last step.
- pickup is registered. It is high for the one cycle following the edge that cleared the cell, aligned with the score increment.
- m* inputs are sampled at the step's commit edge.
- Loads are visible on sensors the cycle after the write edge.

## Test plan
- Reset: drive resetN low mid-cycle. Outputs clear immediately: posX=5, posY=5, score=0, busy=0, done=0, sensors 0.
- Load and pickup: load col 5 = 'b0000100000 and col 6 = 'b0000100000. lRight=1 in IDLE. Pulse start with m*=0. First step: pickup=1, score=1, cell(5,5) cleared. Following steps: pickup=0, score stays 1.
- Wrap: start, hold mLeft. posX sequence 5,4,3,2,1,0,9. Hold mDown from y=0: posY goes to 9.
- Cancel and diagonal: mUp=mDown=1 leaves posY unchanged. mUp=mRight=1 from (5,5) moves to (6,6).
- Run control: STEPS=4. busy high 4 cycles, then done=1. start and load pulsed during RUN have no effect. start in DONE re-centres to (5,5), score=0, grid retained.
- Reset mid-run: assert resetN low at step 2 with score=1. Block immediately goes to IDLE: grid 0, score 0, busy 0.
